// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - serial-to-parallel word assembler with hold/overrun handshake
module serial_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       din,
   input  logic                       din_en,
   input  logic                       start,
   output logic [WIDTH-1:0]           dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic                       overrun,
   input  logic                       ovr_clr,
   output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] first_word;
   logic [WIDTH-1:0] next_word;
   logic             shift_en;
   logic             complete;

   // Candidate shift-register contents for a frame start and for a continuing bit.
   always_comb begin
      first_word = '0;
      if (MSB_FIRST) begin
         first_word[0] = din;
         next_word     = {sr[WIDTH-2:0], din};
      end else begin
         first_word[WIDTH-1] = din;
         next_word           = {din, sr[WIDTH-1:1]};
      end
      shift_en = din_en && !start && (state == SHIFT);
      complete = shift_en && (bit_cnt == LAST);
   end

   // Frame FSM, shift register, output holding register and sticky overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sr         <= '0;
         bit_cnt    <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         // A start always resynchronises, discarding any partial frame.
         if (din_en && start) begin
            sr      <= first_word;
            bit_cnt <= CW'(1);
            state   <= SHIFT;
         end else if (shift_en) begin
            sr      <= next_word;
            bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
         end

         // A finished word is loaded only when the holding register is free or being drained.
         if (complete) begin
            if (!dout_valid || dout_ready) begin
               dout       <= next_word;
               dout_valid <= 1'b1;
            end
         end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
         end

         // A new drop outranks a simultaneous clear.
         if (complete && dout_valid && !dout_ready) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - scoreboard bench for serial_deserializer (MSB and LSB first)
module tb_serial_deserializer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       din;
   logic       din_en;
   logic       start;
   logic       dout_ready;
   logic       ovr_clr;
   logic [7:0] dout_m, dout_l;
   logic       v_m, v_l;
   logic       ovr_m, ovr_l;
   logic [2:0] cnt_m, cnt_l;

   int total = 0;
   int bad   = 0;

   logic [7:0] q_m[$];
   logic [7:0] q_l[$];

   logic pv_m = 1'b0, pr_m = 1'b0;
   logic pv_l = 1'b0, pr_l = 1'b0;

   serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .start(start),
      .dout(dout_m), .dout_valid(v_m), .dout_ready(dout_ready),
      .overrun(ovr_m), .ovr_clr(ovr_clr), .bit_cnt(cnt_m)
   );

   serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .start(start),
      .dout(dout_l), .dout_valid(v_l), .dout_ready(dout_ready),
      .overrun(ovr_l), .ovr_clr(ovr_clr), .bit_cnt(cnt_l)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rev8(input logic [7:0] w);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = w[7-i];
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic put_bit(input logic b, input logic st);
      din    = b;
      start  = st;
      din_en = 1'b1;
      @(posedge clk);
      #1;
      din_en = 1'b0;
      start  = 1'b0;
      din    = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_word(input logic [7:0] w);
      q_m.push_back(w);
      q_l.push_back(rev8(w));
   endtask

   task automatic send_word(input logic [7:0] w, input logic st, input logic keep);
      if (keep) expect_word(w);
      for (int i = 0; i < 8; i++) put_bit(w[7-i], st && (i == 0));
   endtask

   // MSB-first monitor: a word is new when valid rises or follows a completed handshake.
   always @(negedge clk) begin
      if (rst_n && v_m && (!pv_m || pr_m)) begin
         if (q_m.size() == 0) begin
            total++;
            bad++;
            $display("FAIL msb_unexpected_word: got 0x%0h expected none", dout_m);
         end else begin
            chk("msb_word", int'(dout_m), int'(q_m.pop_front()));
         end
      end
      pv_m = rst_n && v_m;
      pr_m = dout_ready;
   end

   // LSB-first monitor, same presentation rule.
   always @(negedge clk) begin
      if (rst_n && v_l && (!pv_l || pr_l)) begin
         if (q_l.size() == 0) begin
            total++;
            bad++;
            $display("FAIL lsb_unexpected_word: got 0x%0h expected none", dout_l);
         end else begin
            chk("lsb_word", int'(dout_l), int'(q_l.pop_front()));
         end
      end
      pv_l = rst_n && v_l;
      pr_l = dout_ready;
   end

   initial begin
      logic [7:0] w;
      logic [7:0] bits3;
      rst_n      = 1'b1;
      din        = 1'b0;
      din_en     = 1'b0;
      start      = 1'b0;
      dout_ready = 1'b1;
      ovr_clr    = 1'b0;

      // reset between edges, observed before any clock edge
      #2 rst_n = 1'b0;
      #1;
      chk("rst_dout",  int'(dout_m), 0);
      chk("rst_valid", int'(v_m),    0);
      chk("rst_ovr",   int'(ovr_m),  0);
      chk("rst_cnt",   int'(cnt_m),  0);
      @(negedge clk);
      rst_n = 1'b1;
      gap(1);

      // bits without start in IDLE are ignored
      put_bit(1'b1, 1'b0);
      chk("idle_ignore_cnt", int'(cnt_m), 0);

      // basic frame 0xB2 (LSB-first instance sees 0x4D)
      send_word(8'hB2, 1'b1, 1'b1);
      chk("b2_valid_now", int'(v_m), 1);
      chk("b2_cnt_wrap",  int'(cnt_m), 0);
      chk("b2_lsb_value", int'(dout_l), 8'h4D);
      gap(1);
      chk("b2_valid_one_cycle", int'(v_m), 0);

      // overrun with consumer stalled
      dout_ready = 1'b0;
      send_word(8'hB2, 1'b1, 1'b1);
      send_word(8'hFF, 1'b1, 1'b0);
      chk("ovr_dout_hold", int'(dout_m), 8'hB2);
      chk("ovr_lsb_hold",  int'(dout_l), 8'h4D);
      chk("ovr_set",       int'(ovr_m),  1);
      chk("ovr_set_lsb",   int'(ovr_l),  1);
      chk("ovr_valid",     int'(v_m),    1);
      ovr_clr = 1'b1;
      gap(1);
      ovr_clr = 1'b0;
      chk("ovr_cleared", int'(ovr_m), 0);
      dout_ready = 1'b1;
      gap(1);
      chk("drain_valid", int'(v_m), 0);

      // resync: partial frame then a fresh start
      bits3 = 8'b1010_0000;
      for (int i = 0; i < 3; i++) put_bit(bits3[7-i], i == 0);
      chk("resync_partial_cnt", int'(cnt_m), 3);
      send_word(8'h5A, 1'b1, 1'b1);
      chk("resync_no_ovr", int'(ovr_m), 0);
      gap(2);

      // gaps between bits
      expect_word(8'hC3);
      w = 8'hC3;
      for (int i = 0; i < 8; i++) begin
         put_bit(w[7-i], i == 0);
         if (i < 7) begin
            gap((i % 4) + 1);
            chk("gap_cnt_hold", int'(cnt_m), i + 1);
         end
      end
      gap(2);

      // back-to-back frames from a single start
      expect_word(8'hA5);
      expect_word(8'h3C);
      for (int i = 0; i < 16; i++) begin
         w = (i < 8) ? 8'hA5 : 8'h3C;
         put_bit(w[7 - (i % 8)], i == 0);
         if (i == 6)  chk("b2b_cnt7", int'(cnt_m), 7);
         if (i == 7)  chk("b2b_wrap_a", int'(cnt_m), 0);
         if (i == 15) chk("b2b_wrap_b", int'(cnt_m), 0);
      end

      // reset mid third frame
      bits3 = 8'b1101_0000;
      for (int i = 0; i < 5; i++) put_bit(bits3[7-i], 1'b0);
      chk("third_cnt5", int'(cnt_m), 5);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_dout",     int'(dout_m), 0);
      chk("midrst_dout_lsb", int'(dout_l), 0);
      chk("midrst_valid",    int'(v_m),    0);
      chk("midrst_ovr",      int'(ovr_m),  0);
      chk("midrst_cnt",      int'(cnt_m),  0);
      @(negedge clk);
      rst_n = 1'b1;
      gap(1);
      for (int i = 0; i < 8; i++) put_bit(1'b1, 1'b0);
      chk("post_rst_ignore_cnt", int'(cnt_m), 0);
      chk("post_rst_no_valid",   int'(v_m),   0);
      gap(3);

      chk("queue_left", q_m.size() + q_l.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first serial bit lands in dout[WIDTH-1]; 0 = first serial bit lands in dout[0].
REQ-003 Port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port din  input  1  serial data bit, normally driven by the upstream D flip-flop q.
REQ-006 Port din_en  input  1  qualifies din; a bit is accepted only on an edge where din_en=1.
REQ-007 Port start  input  1  frame-start marker; meaningful only when din_en=1.
REQ-008 Port dout  output  WIDTH  assembled parallel word.
REQ-009 Port dout_valid  output  1  dout holds an unconsumed word.
REQ-010 Port dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1 and dout_ready=1.
REQ-011 Port overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 Port ovr_clr  input  1  synchronous clear of overrun.
REQ-013 Port bit_cnt  output  ceil(log2(WIDTH))  number of bits accepted in the current partial frame.

Function
REQ-014 The block SHALL have two states, IDLE and SHIFT; IDLE after reset.
REQ-015 In IDLE, din_en=1 with start=0 SHALL be ignored; bit_cnt stays 0.
REQ-016 In either state, din_en=1 with start=1 SHALL discard any partial frame, accept din as bit 1 of a new frame, set bit_cnt=1, and enter or stay in SHIFT.
REQ-017 In SHIFT, din_en=1 with start=0 SHALL shift din into the shift register per MSB_FIRST and increment bit_cnt.
REQ-018 On the edge accepting the WIDTH-th bit, bit_cnt SHALL wrap to 0 and the state SHALL remain SHIFT (back-to-back frames need no new start).
REQ-019 Completed word transfer: on that edge, if dout_valid=0, or dout_valid=1 and dout_ready=1, dout SHALL load the word and dout_valid SHALL be 1 after the edge (latency one edge from last bit).
REQ-020 If dout_valid=1 and dout_ready=0 on the completing edge, the new word SHALL be dropped, dout unchanged, and overrun set to 1.
REQ-021 dout_valid=1 and dout_ready=1 with no word completing SHALL clear dout_valid; dout value may remain but is not valid.
REQ-022 dout SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-023 Edges with din_en=0 SHALL leave shift register, bit_cnt and state unchanged (gaps of any length allowed).
REQ-024 ovr_clr=1 SHALL clear overrun on the next edge; a simultaneous new overrun event SHALL win (overrun=1).
REQ-025 dout_ready SHALL be ignored while dout_valid=0.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, shift register 0, bit_cnt 0, dout 0, dout_valid 0, overrun 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release, a start is required before bits are accepted.
REQ-028 The first rising clk edge after rst_n deasserts SHALL operate normally.

Verification (WIDTH=8 unless noted)
REQ-029 Reset: drive rst_n=0 between clock edges -> dout=0x00, dout_valid=0, overrun=0, bit_cnt=0 with no edge needed.
REQ-030 MSB_FIRST=1, dout_ready=1: start on first bit, serial 1,0,1,1,0,0,1,0 -> dout=0xB2, dout_valid=1 for exactly one cycle; MSB_FIRST=0 same bits -> dout=0x4D.
REQ-031 dout_ready=0: two full frames 0xB2 then 0xFF -> dout stays 0xB2, overrun=1; pulse ovr_clr -> overrun=0; then ready=1 -> dout_valid=0.
REQ-032 Resync: 3 bits then start with new 8-bit frame 0x5A -> single word 0x5A output, no overrun.
REQ-033 Gaps: frame 0xC3 with din_en=0 inserted for 1..4 cycles between bits -> dout=0xC3, bit_cnt holds during gaps.
REQ-034 Back-to-back: start once, 16 bits 0xA5 then 0x3C with dout_ready=1 -> two words in order, bit_cnt wraps 7->0; rst_n pulse after bit 5 of a third frame -> all outputs 0, later bits without start ignored.
